// File: rtl/mux4_rr_arbiter_if.sv
// Handshake and select bundle between mux4_rr_arbiter, its four sources
// and the single consumer of the shared 32-bit bus.
//   master : the arbiter (drives sel/gnt/out_valid/xfer_done)
//   slave  : the environment (drives req/out_ready)
interface mux4_rr_arbiter_if;
  logic [3:0] req;        // request per source, bit i = mux input i
  logic       out_ready;  // consumer accepts the current word
  logic [1:0] sel;        // mux_4x1 select
  logic [3:0] gnt;        // one-hot grant, zero when idle
  logic       out_valid;  // shared-bus word valid
  logic       xfer_done;  // registered pulse after each accepted word

  modport master (
    input  req,
    input  out_ready,
    output sel,
    output gnt,
    output out_valid,
    output xfer_done
  );

  modport slave (
    output req,
    output out_ready,
    input  sel,
    input  gnt,
    input  out_valid,
    input  xfer_done
  );
endinterface

// File: rtl/mux4_rr_arbiter.sv
// Round-robin scheduler for a shared 4:1 32-bit mux. Grants one of four
// requesters, drives the mux select and runs valid/ready toward the consumer.
// Re-arbitration happens on the same edge as a transfer or a withdraw, so
// back-to-back grants carry no idle bubble.
//
// Optional feature: define MUX_ARB_HOLD_EN to let a source keep the grant for
// up to MAX_HOLD consecutive transfers while it keeps requesting.
module mux4_rr_arbiter #(
  parameter int unsigned MAX_HOLD  = 4,
  parameter logic [1:0]  RESET_PTR = 2'd3
) (
  input  logic                clk,
  input  logic                reset,
  mux4_rr_arbiter_if.master   bus
);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e     state_q, state_d;
  logic [1:0] sel_q, sel_d;
  logic [1:0] last_q, last_d;
  logic [3:0] gnt_q, gnt_d;
  logic       xfer_done_q, xfer_done_d;

`ifdef MUX_ARB_HOLD_EN
  localparam logic [3:0] HoldLimit = 4'(MAX_HOLD - 1);
  logic [3:0] hold_cnt_q, hold_cnt_d;
`endif

  // MAX_HOLD must lie in 1..15; an out-of-range value leaves this scope visible
  // in the elaborated hierarchy.
  if (MAX_HOLD < 1 || MAX_HOLD > 15) begin : g_max_hold_out_of_range
  end

  logic       out_valid;
  logic       xfer;
  logic [1:0] search_ptr;
  logic [2:0] pick;       // {found, index}
  logic       rearb;

  // First set bit of r at or after ptr+1, wrapping mod 4; ptr itself is last.
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] ptr);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    // Walk from farthest to nearest so the nearest hit is the one kept.
    for (int k = 4; k >= 1; k--) begin
      idx = ptr + k[1:0];
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  assign out_valid  = (state_q == StGrant) & bus.req[sel_q];
  assign xfer       = out_valid & bus.out_ready;
  // Idle searches after the last served source; a live grant searches after itself.
  assign search_ptr = (state_q == StIdle) ? last_q : sel_q;
  assign pick       = rr_pick(bus.req, search_ptr);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and next register values, including re-arbitration.
  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    gnt_d       = gnt_q;
    last_d      = last_q;
    xfer_done_d = 1'b0;
    rearb       = 1'b0;
`ifdef MUX_ARB_HOLD_EN
    hold_cnt_d  = hold_cnt_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (pick[2]) rearb = 1'b1;
      end
      StGrant: begin
        if (xfer) begin
          xfer_done_d = 1'b1;
          last_d      = sel_q;
`ifdef MUX_ARB_HOLD_EN
          // A transfer implies req[sel] is still high, so only the budget matters.
          if (hold_cnt_q < HoldLimit) begin
            hold_cnt_d = hold_cnt_q + 4'd1;
          end else begin
            rearb = 1'b1;
          end
`else
          rearb = 1'b1;
`endif
        end else if (!bus.req[sel_q]) begin
          // Withdraw: treat the source as served and move on.
          last_d = sel_q;
          rearb  = 1'b1;
        end
      end
      default: ;
    endcase

    if (rearb) begin
`ifdef MUX_ARB_HOLD_EN
      hold_cnt_d = 4'd0;
`endif
      if (pick[2]) begin
        state_d = StGrant;
        sel_d   = pick[1:0];
        gnt_d   = 4'b0001 << pick[1:0];
      end else begin
        state_d = StIdle;
        gnt_d   = 4'b0000;
      end
    end
  end

  // Registered datapath: select, grant, pointer, done pulse, hold counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      sel_q       <= 2'd0;
      gnt_q       <= 4'b0000;
      last_q      <= RESET_PTR;
      xfer_done_q <= 1'b0;
`ifdef MUX_ARB_HOLD_EN
      hold_cnt_q  <= 4'd0;
`endif
    end else begin
      sel_q       <= sel_d;
      gnt_q       <= gnt_d;
      last_q      <= last_d;
      xfer_done_q <= xfer_done_d;
`ifdef MUX_ARB_HOLD_EN
      hold_cnt_q  <= hold_cnt_d;
`endif
    end
  end

  // Outputs: all registered except out_valid.
  always_comb begin
    bus.sel       = sel_q;
    bus.gnt       = gnt_q;
    bus.xfer_done = xfer_done_q;
    bus.out_valid = out_valid;
  end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed scenarios followed by random traffic, every cycle checked against a
// behavioural round-robin model that tracks "who holds the grant" as an integer.
module tb_mux4_rr_arbiter;

  localparam int unsigned MaxHold = 4;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  mux4_rr_arbiter_if bus ();

  mux4_rr_arbiter #(
    .MAX_HOLD  (MaxHold),
    .RESET_PTR (2'd3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Model: m_grant = -1 when nobody holds the bus, else the granted index.
  int m_grant;
  int m_sel;
  int m_last;
  int m_hold;
  bit m_xfer;
  bit m_known = 1'b0;
  logic last_ov;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [3:0] r, input int p);
    for (int k = 1; k <= 4; k++) begin
      int i;
      i = (p + k) % 4;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_rearb(input logic [3:0] r);
    int w;
    w = pick(r, m_grant);
    m_hold = 0;
    if (w < 0) begin
      m_grant = -1;
    end else begin
      m_grant = w;
      m_sel   = w;
    end
  endtask

  task automatic model_edge(input logic [3:0] r, input logic rdy, input logic rst);
    int w;
    if (rst) begin
      m_grant = -1; m_sel = 0; m_last = 3; m_hold = 0; m_xfer = 1'b0;
      m_known = 1'b1;
      return;
    end
    m_xfer = 1'b0;
    if (m_grant < 0) begin
      w = pick(r, m_last);
      if (w >= 0) begin
        m_grant = w; m_sel = w; m_hold = 0;
      end
    end else if (r[m_grant] && rdy) begin
      m_xfer = 1'b1;
      m_last = m_grant;
`ifdef MUX_ARB_HOLD_EN
      if (m_hold < int'(MaxHold) - 1) m_hold++;
      else model_rearb(r);
`else
      model_rearb(r);
`endif
    end else if (!r[m_grant]) begin
      m_last = m_grant;
      model_rearb(r);
    end
  endtask

  function automatic logic exp_ov(input logic [3:0] r);
    return (m_grant >= 0) && r[m_grant];
  endfunction

  function automatic logic [3:0] exp_gnt();
    return (m_grant < 0) ? 4'b0000 : (4'b0001 << m_grant);
  endfunction

  // One clock: drive at negedge, check out_valid, advance model at posedge,
  // then check registered outputs just after the edge.
  task automatic apply(input logic [3:0] r, input logic rdy, input logic rst);
    @(negedge clk);
    reset         = rst;
    bus.req       = r;
    bus.out_ready = rdy;
    #1;
    last_ov = bus.out_valid;
    if (m_known) check("out_valid", {3'b000, bus.out_valid}, {3'b000, exp_ov(r)});
    @(posedge clk);
    model_edge(r, rdy, rst);
    #1;
    check("gnt", bus.gnt, exp_gnt());
    check("sel", {2'b00, bus.sel}, 4'(m_sel));
    check("xfer_done", {3'b000, bus.xfer_done}, {3'b000, m_xfer});
  endtask

  initial begin
    int seq[4];
    logic [3:0] r;
    reset         = 1'b1;
    bus.req       = 4'b0000;
    bus.out_ready = 1'b0;

    // Reset held two cycles with every source requesting.
    apply(4'b1111, 1'b0, 1'b1);
    apply(4'b1111, 1'b0, 1'b1);
    check("rst_gnt", bus.gnt, 4'b0000);
    check("rst_sel", {2'b00, bus.sel}, 4'd0);
    check("rst_out_valid", {3'b000, bus.out_valid}, 4'd0);
    apply(4'b1111, 1'b1, 1'b0);
    check("rel_gnt", bus.gnt, 4'b0001);

    // Rotation with everyone requesting and the consumer always ready.
`ifdef MUX_ARB_HOLD_EN
    seq = '{0, 0, 0, 1};
`else
    seq = '{1, 2, 3, 0};
`endif
    for (int i = 0; i < 4; i++) begin
      apply(4'b1111, 1'b1, 1'b0);
      check("rot_sel", {2'b00, bus.sel}, 4'(seq[i]));
      check("rot_xfer", {3'b000, bus.xfer_done}, 4'd1);
    end

    // Stall: src 1 granted, consumer not ready for 5 cycles.
    apply(4'b0110, 1'b0, 1'b1);
    apply(4'b0110, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      apply(4'b0110, 1'b0, 1'b0);
      check("stall_gnt", bus.gnt, 4'b0010);
    end
    apply(4'b0110, 1'b1, 1'b0);
`ifndef MUX_ARB_HOLD_EN
    check("stall_next_sel", {2'b00, bus.sel}, 4'd2);
`endif

    // Withdraw: src 2 granted, then drops while 0 and 3 request.
    apply(4'b0100, 1'b0, 1'b1);
    apply(4'b0100, 1'b0, 1'b0);
    apply(4'b0100, 1'b0, 1'b0);
    apply(4'b1001, 1'b0, 1'b0);
    check("wd_out_valid", {3'b000, last_ov}, 4'd0);
    check("wd_gnt", bus.gnt, 4'b1000);
    check("wd_xfer", {3'b000, bus.xfer_done}, 4'd0);

    // Reset while src 2 is presenting a valid word.
    apply(4'b0100, 1'b0, 1'b1);
    apply(4'b0100, 1'b0, 1'b0);
    apply(4'b0110, 1'b0, 1'b1);
    check("midrst_ov", {3'b000, last_ov}, 4'd1);
    check("midrst_gnt", bus.gnt, 4'b0000);
    apply(4'b0110, 1'b0, 1'b0);
    check("midrst_regnt", bus.gnt, 4'b0010);

`ifdef MUX_ARB_HOLD_EN
    // Burst hold: four transfers per grant.
    seq = '{0, 0, 0, 1};
    apply(4'b0011, 1'b1, 1'b1);
    apply(4'b0011, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      apply(4'b0011, 1'b1, 1'b0);
      check("hold_sel", {2'b00, bus.sel}, 4'((i < 3) ? 0 : (i < 7) ? 1 : 0));
    end
`endif

    // Random traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      r = 4'($urandom_range(0, 15));
      apply(r, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 49) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
